// File: rtl/nios_sram_pkg.sv
// Shared SRAM constants and types for the Nios II / DMA on-chip SRAM arbiter.
package nios_sram_pkg;

    localparam int SRAM_ADDR_W = 15;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_BE_W   = 4;
    localparam int SRAM_DEPTH  = 20480;
    localparam int SRAM_RD_LAT = 1;

    // Master identity: the Nios II data master and the DMA / video-read master
    typedef enum logic {
        MST_NIOS = 1'b0,
        MST_DMA  = 1'b1
    } master_e;

    // One master's Avalon request as seen by the arbiter
    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] address;
        logic [SRAM_BE_W-1:0]   byteenable;
        logic [SRAM_DATA_W-1:0] writedata;
        logic                   read;
        logic                   write;
    } sram_req_t;

endpackage

// File: rtl/nios_sram_rr_grant.sv
// Two-way round-robin grant core that lets one master hold the port for a
// bounded number of consecutive cycles while the other is also requesting.
module nios_sram_rr_grant
    import nios_sram_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    master_e    r_last;
    logic [3:0] r_hold_cnt;

    master_e    w_gnt_id;
    logic       w_any;
    logic       w_hold_ok;

    // Pick the winner; a non-zero hold count means the last master was granted
    // (and therefore requested) in the previous cycle, so it may keep the port
    always_comb begin
        w_any     = |i_req;
        w_hold_ok = (r_hold_cnt != 4'd0) && (r_hold_cnt < HOLD_LIM);
        w_gnt_id  = MST_NIOS;
        o_gnt     = 2'b00;
        case (i_req)
            2'b01:   w_gnt_id = MST_NIOS;
            2'b10:   w_gnt_id = MST_DMA;
            2'b11:   w_gnt_id = w_hold_ok ? r_last
                                          : ((r_last == MST_NIOS) ? MST_DMA : MST_NIOS);
            default: w_gnt_id = MST_NIOS;
        endcase
        if (w_any) begin
            o_gnt = (w_gnt_id == MST_DMA) ? 2'b10 : 2'b01;
        end
    end

    // Track who was granted last and how long they have held the port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last     <= MST_DMA;
            r_hold_cnt <= 4'd0;
        end else if (w_any) begin
            r_last <= w_gnt_id;
            if (w_gnt_id == r_last) begin
                r_hold_cnt <= (r_hold_cnt == 4'hF) ? 4'hF : r_hold_cnt + 4'd1;
            end else begin
                r_hold_cnt <= 4'd1;
            end
        end else begin
            r_hold_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/nios_sram_arbiter.sv
// Arbiter sharing the single-port on-chip SRAM between the Nios II data
// master and a DMA / video-read master, with pipelined read return.
module nios_sram_arbiter
    import nios_sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int BE_W     = SRAM_BE_W,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic [BE_W-1:0]   s_byteenable,
    output logic              s_chipselect,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic              s_clken,
    input  logic [DATA_W-1:0] s_readdata
);

    sram_req_t  w_m0;
    sram_req_t  w_m1;
    sram_req_t  w_sel;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_any_gnt;
    logic       w_rd_accept;

    logic       r_rd_pend;
    master_e    r_rd_owner;

    // Requests are masked while reset is held so nobody sees an accept
    assign w_req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

    nios_sram_rr_grant #(
        .HOLD_MAX (HOLD_MAX)
    ) u_grant (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // Gather each master's request and steer the granted one onto the SRAM port;
    // with no grant the master-0 request sits on the don't-care address/data lines
    always_comb begin
        w_m0.address    = m0_address;
        w_m0.byteenable = m0_byteenable;
        w_m0.writedata  = m0_writedata;
        w_m0.read       = m0_read;
        w_m0.write      = m0_write;
        w_m1.address    = m1_address;
        w_m1.byteenable = m1_byteenable;
        w_m1.writedata  = m1_writedata;
        w_m1.read       = m1_read;
        w_m1.write      = m1_write;
        w_sel           = w_gnt[1] ? w_m1 : w_m0;
        w_any_gnt       = |w_gnt;
        w_rd_accept     = w_any_gnt & w_sel.read & ~w_sel.write;
    end

    assign s_address      = w_sel.address;
    assign s_byteenable   = w_sel.byteenable;
    assign s_writedata    = w_sel.writedata;
    assign s_chipselect   = w_any_gnt;
    assign s_write        = w_any_gnt & w_sel.write;
    assign s_clken        = 1'b1;

    assign m0_waitrequest = ~w_gnt[0];
    assign m1_waitrequest = ~w_gnt[1];

    // Remember an accepted read so its data can be flagged to the owner one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= MST_NIOS;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_owner <= w_gnt[1] ? MST_DMA : MST_NIOS;
            end
        end
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = r_rd_pend & (r_rd_owner == MST_NIOS);
    assign m1_readdatavalid = r_rd_pend & (r_rd_owner == MST_DMA);

endmodule

// File: tb/tb_nios_sram_arbiter.sv
// Testbench for nios_sram_arbiter: SRAM stand-in, reference model and directed tests.
module tb_nios_sram_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int DEPTH    = 20480;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [14:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_chipselect, s_write, s_clken;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    int checks = 0;
    int passes = 0;

    logic [31:0] sramMem [0:DEPTH-1];
    logic [31:0] refMem  [0:DEPTH-1];

    int          mLast;
    int          streak;
    bit          prevReq0, prevReq1;
    bit          pend;
    int          pendOwner;
    logic [31:0] pendData;
    int          waitCnt0, waitCnt1;

    always #5 clk = ~clk;

    nios_sram_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_byteenable     (s_byteenable),
        .s_chipselect     (s_chipselect),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_clken          (s_clken),
        .s_readdata       (s_readdata)
    );

    // SRAM stand-in: byte-lane writes, read data registered one cycle after the address
    always @(posedge clk) begin
        if (s_chipselect) begin
            if (s_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_byteenable[b]) sramMem[s_address][8*b +: 8] <= s_writedata[8*b +: 8];
                end
            end else begin
                s_readdata <= sramMem[s_address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [14:0] a0,
                                 input logic [3:0] be0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [14:0] a1,
                                 input logic [3:0] be1, input logic [31:0] d1);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 15'h0, 4'h0, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        idle();
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
    endtask

    // Reference model: grant by the round-robin/hold rules, memory with byte lanes,
    // read data expected one cycle after acceptance; compared every falling edge
    always @(negedge clk) begin : compare
        logic r0, r1, lastReq, gWrite, gRead;
        logic [14:0] gAddr;
        logic [3:0]  gBe;
        logic [31:0] gData;
        int g;
        if (!reset_n) begin
            checkOutput("rst_m0_wait", m0_waitrequest, 1);
            checkOutput("rst_m1_wait", m1_waitrequest, 1);
            checkOutput("rst_cs", s_chipselect, 0);
            checkOutput("rst_s_write", s_write, 0);
            checkOutput("rst_m0_valid", m0_readdatavalid, 0);
            checkOutput("rst_m1_valid", m1_readdatavalid, 0);
            mLast = 1; streak = 0; prevReq0 = 0; prevReq1 = 0; pend = 0;
            waitCnt0 = 0; waitCnt1 = 0;
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (r0 && !r1) g = 0;
            else if (r1 && !r0) g = 1;
            else if (r0 && r1) begin
                lastReq = (mLast == 0) ? prevReq0 : prevReq1;
                g = (lastReq && streak < HOLD_MAX) ? mLast : 1 - mLast;
            end else g = -1;

            gRead  = (g == 1) ? m1_read       : m0_read;
            gWrite = (g == 1) ? m1_write      : m0_write;
            gAddr  = (g == 1) ? m1_address    : m0_address;
            gBe    = (g == 1) ? m1_byteenable : m0_byteenable;
            gData  = (g == 1) ? m1_writedata  : m0_writedata;

            checkOutput("m0_wait", m0_waitrequest, g != 0);
            checkOutput("m1_wait", m1_waitrequest, g != 1);
            checkOutput("s_cs", s_chipselect, g >= 0);
            checkOutput("s_write", s_write, (g >= 0) && gWrite);
            if (g >= 0) begin
                checkOutput("s_addr", s_address, gAddr);
                checkOutput("s_be", s_byteenable, gBe);
                if (gWrite) checkOutput("s_wdata", s_writedata, gData);
            end
            checkOutput("m0_valid", m0_readdatavalid, pend && pendOwner == 0);
            checkOutput("m1_valid", m1_readdatavalid, pend && pendOwner == 1);
            if (pend) checkOutput("rdata", (pendOwner == 0) ? m0_readdata : m1_readdata, pendData);

            if (r0) begin
                if (!m0_waitrequest) begin
                    checkOutput("fair_m0", waitCnt0 <= HOLD_MAX, 1);
                    waitCnt0 = 0;
                end else waitCnt0++;
            end else waitCnt0 = 0;
            if (r1) begin
                if (!m1_waitrequest) begin
                    checkOutput("fair_m1", waitCnt1 <= HOLD_MAX, 1);
                    waitCnt1 = 0;
                end else waitCnt1++;
            end else waitCnt1 = 0;

            pend = (g >= 0) && gRead && !gWrite;
            if (g >= 0) begin
                pendOwner = g;
                pendData  = refMem[gAddr];
                if (gWrite) begin
                    for (int b = 0; b < 4; b++)
                        if (gBe[b]) refMem[gAddr][8*b +: 8] = gData[8*b +: 8];
                end
                streak = (g == mLast) ? streak + 1 : 1;
                mLast  = g;
            end else streak = 0;
            prevReq0 = r0;
            prevReq1 = r1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sramMem[i] = 32'h0;
            refMem[i]  = 32'h0;
        end
        sramMem[16'h0010] = 32'hDEADBEEF;
        refMem[16'h0010]  = 32'hDEADBEEF;
        s_readdata = 32'h0;

        // Requests during reset must not be accepted
        reset_n = 1'b0;
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("rst_req_m0_wait", m0_waitrequest, 1);
        checkOutput("rst_req_cs", s_chipselect, 0);
        nextCycle();
        idle();
        nextCycle();
        reset_n = 1'b1;

        // Single read by m0
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("t1_m0_wait", m0_waitrequest, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t1_m0_valid", m0_readdatavalid, 1);
        checkOutput("t1_m0_rdata", m0_readdata, 32'hDEADBEEF);
        checkOutput("t1_m1_valid", m1_readdatavalid, 0);
        nextCycle();

        // Tie right after reset: m0 first, then m1
        pulseReset();
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("tie_m0_wait", m0_waitrequest, 0);
        checkOutput("tie_m1_wait", m1_waitrequest, 1);
        nextCycle();
        applyStimulus(0, 0, 15'h0, 4'h0, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("tie_m1_gnt", m1_waitrequest, 0);
        nextCycle();
        idle();
        nextCycle();

        // Bounded hold with both masters requesting continuously
        pulseReset();
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0200, 4'hF, 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_m0_gnt_%0d", i), !m0_waitrequest, ((i / 4) % 2) == 0);
            nextCycle();
        end
        idle();
        nextCycle();

        // Byte-enable write by m1, read back by m0
        applyStimulus(0, 0, 15'h0, 4'h0, 32'h0, 0, 1, 15'h0200, 4'b0101, 32'h11223344);
        nextCycle();
        applyStimulus(1, 0, 15'h0200, 4'hF, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("be_m0_valid", m0_readdatavalid, 1);
        checkOutput("be_m0_rdata", m0_readdata, 32'h00220044);
        nextCycle();

        // Read and write together on one master behave as a write
        applyStimulus(1, 1, 15'h0300, 4'hF, 32'hCAFEF00D, 0, 0, 15'h0, 4'h0, 32'h0);
        nextCycle();
        applyStimulus(1, 0, 15'h0300, 4'hF, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("rw_no_valid", m0_readdatavalid, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("rw_rdata", m0_readdata, 32'hCAFEF00D);
        nextCycle();

        // Interleaved reads: m0 then m1
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 15'h0, 4'h0, 32'h0, 1, 0, 15'h0200, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("il_n1_m0_valid", m0_readdatavalid, 1);
        checkOutput("il_n1_m1_valid", m1_readdatavalid, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("il_n2_m0_valid", m0_readdatavalid, 0);
        checkOutput("il_n2_m1_valid", m1_readdatavalid, 1);
        checkOutput("il_n2_m1_rdata", m1_readdata, 32'h00220044);
        nextCycle();

        // Reset in the cycle after an accepted m0 read drops its return
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 0, 0, 15'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("mr_m0_gnt", m0_waitrequest, 0);
        nextCycle();
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        checkOutput("mr_m0_valid", m0_readdatavalid, 0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1, 0, 15'h0010, 4'hF, 32'h0, 1, 0, 15'h0020, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("mr_tie_m0_wait", m0_waitrequest, 0);
        checkOutput("mr_tie_m1_wait", m1_waitrequest, 1);
        nextCycle();
        idle();
        nextCycle();
        nextCycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
